// File: rtl/rps_pkg.sv
// Shared definitions for the rotating-priority-selector requester: channel count,
// index and pending-count types, default starvation limit and a one-hot encoder.
package rps_pkg;

    localparam int NUM_CH            = 4;
    localparam int DEF_CNT_W         = 3;
    localparam int DEF_STARVE_LIMIT  = 8;

    typedef logic [1:0]           ch_idx_t;
    typedef logic [DEF_CNT_W-1:0] cnt_t;

    function automatic ch_idx_t onehot_idx(input logic [NUM_CH-1:0] vec);
        ch_idx_t idx;
        idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (vec[i]) idx = ch_idx_t'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rps_requester_if.sv
// Requester <-> selector signal bundle; master is the requester side, slave the
// selector/environment side.
interface rps_requester_if;
    import rps_pkg::*;

    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] gnt;
    logic [NUM_CH-1:0] req;
    logic              en;
    logic [NUM_CH-1:0] full;
    logic              served_valid;
    ch_idx_t           served_id;
    logic [NUM_CH-1:0] overflow;
    logic              gnt_err;
    logic [NUM_CH-1:0] starve;

    modport master (
        input  push, gnt,
        output req, en, full, served_valid, served_id, overflow, gnt_err, starve
    );

    modport slave (
        output push, gnt,
        input  req, en, full, served_valid, served_id, overflow, gnt_err, starve
    );

endinterface

// File: rtl/rps_chan.sv
// One requester channel: saturating pending-job counter, full/overflow flags and,
// when RPS_STARVE_MON_EN is defined, a wait counter driving starve.
module rps_chan #(
    parameter int CNT_W        = 3,
    parameter int STARVE_LIMIT = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic push,
    input  logic gnt_bit,
    input  logic take,
    output logic req,
    output logic full,
    output logic overflow,
    output logic starve
);

    localparam logic [CNT_W-1:0] MAX_CNT = '1;

    logic [CNT_W-1:0] count;

    assign req  = (count != '0);
    assign full = (count == MAX_CNT);

    // A push paired with an accepted grant is a net no-op, even when full.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (push && !take) begin
            if (full) overflow <= 1'b1;
            else      count    <= count + 1'b1;
        end else if (take && !push) begin
            count <= count - 1'b1;
        end
    end

`ifdef RPS_STARVE_MON_EN
    localparam int               WAIT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(STARVE_LIMIT);

    logic [WAIT_W-1:0] wait_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (take || !req) begin
            wait_cnt <= '0;
        end else if (!gnt_bit && wait_cnt != LIMIT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign starve = (wait_cnt >= LIMIT);
`else
    logic unused_gnt_bit;
    assign unused_gnt_bit = gnt_bit;
    assign starve         = 1'b0;
`endif

endmodule

// File: rtl/rps_requester.sv
// Four-channel job requester for a rotating priority selector: validates grants,
// decrements the granted channel and reports the served channel one cycle later.
// Optional starvation monitor enabled by RPS_STARVE_MON_EN.
module rps_requester
    import rps_pkg::*;
#(
    parameter int CNT_W        = DEF_CNT_W,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic           clock,
    input  logic           reset,
    rps_requester_if.master bus
);

    logic [NUM_CH-1:0] req_vec;
    logic [NUM_CH-1:0] full_vec;
    logic [NUM_CH-1:0] ovf_vec;
    logic [NUM_CH-1:0] starve_vec;
    logic [NUM_CH-1:0] take;
    logic              onehot;
    logic              legal;

    // Only a one-hot grant to a channel with pending work is accepted.
    assign onehot = (bus.gnt != '0) && ((bus.gnt & (bus.gnt - 1'b1)) == '0);
    assign legal  = onehot && ((bus.gnt & req_vec) != '0);
    assign take   = legal ? bus.gnt : '0;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        rps_chan #(
            .CNT_W        (CNT_W),
            .STARVE_LIMIT (STARVE_LIMIT)
        ) u_chan (
            .clock    (clock),
            .reset    (reset),
            .push     (bus.push[i]),
            .gnt_bit  (bus.gnt[i]),
            .take     (take[i]),
            .req      (req_vec[i]),
            .full     (full_vec[i]),
            .overflow (ovf_vec[i]),
            .starve   (starve_vec[i])
        );
    end

    assign bus.req      = req_vec;
    assign bus.en       = |req_vec;
    assign bus.full     = full_vec;
    assign bus.overflow = ovf_vec;
    assign bus.starve   = starve_vec;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.gnt_err      <= 1'b0;
            bus.served_valid <= 1'b0;
            bus.served_id    <= '0;
        end else begin
            if (bus.gnt != '0 && !legal) bus.gnt_err <= 1'b1;
            bus.served_valid <= legal;
            if (legal) bus.served_id <= onehot_idx(bus.gnt);
        end
    end

endmodule

// File: tb/tb_rps_requester.sv
// Randomized bench for rps_requester against an integer-level job-queue model;
// directed scenarios first, then random push/grant traffic with async resets.
module tb_rps_requester;
    import rps_pkg::*;

    localparam int CNT_W = 3;
    localparam int LIMIT = 8;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic clock = 1'b0;
    logic reset = 1'b1;

    rps_requester_if bus();

    rps_requester #(.CNT_W(CNT_W), .STARVE_LIMIT(LIMIT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_pass = 0;

    int m_cnt[4];
    int m_wait[4];
    bit m_ovf[4];
    bit m_gerr;
    bit m_sv;
    int m_sid;
    int rr_ptr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            m_cnt[i] = 0; m_wait[i] = 0; m_ovf[i] = 0;
        end
        m_gerr = 0; m_sv = 0; m_sid = 0; rr_ptr = 0;
    endtask

    function automatic logic [3:0] m_req();
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = (m_cnt[i] > 0);
        return r;
    endfunction

    // Job-queue semantics applied at one clock edge.
    task automatic model_edge(input logic [3:0] p, input logic [3:0] g);
        int  idx;
        bit  legal;
        idx = 0;
        for (int i = 0; i < 4; i++) if (g[i]) idx = i;
        legal = ($countones(g) == 1) && (m_cnt[idx] > 0);
        if (g != 0 && !legal) m_gerr = 1;
        for (int i = 0; i < 4; i++) begin
            bit take;
            take = legal && g[i];
            if (take || m_cnt[i] == 0) m_wait[i] = 0;
            else if (!g[i] && m_wait[i] < LIMIT) m_wait[i]++;
            if (p[i] && !take) begin
                if (m_cnt[i] == MAXC) m_ovf[i] = 1;
                else m_cnt[i]++;
            end else if (take && !p[i]) begin
                m_cnt[i]--;
            end
        end
        m_sv = legal;
        if (legal) m_sid = idx;
    endtask

    task automatic check_all(input string tag);
        logic [3:0] full_e, ovf_e, stv_e;
        for (int i = 0; i < 4; i++) begin
            full_e[i] = (m_cnt[i] == MAXC);
            ovf_e[i]  = m_ovf[i];
`ifdef RPS_STARVE_MON_EN
            stv_e[i]  = (m_wait[i] >= LIMIT);
`else
            stv_e[i]  = 1'b0;
`endif
        end
        chk({tag, "_req"},  bus.req, m_req());
        chk({tag, "_en"},   bus.en, m_req() != 0);
        chk({tag, "_full"}, bus.full, full_e);
        chk({tag, "_ovf"},  bus.overflow, ovf_e);
        chk({tag, "_gerr"}, bus.gnt_err, m_gerr);
        chk({tag, "_sv"},   bus.served_valid, m_sv);
        if (m_sv) chk({tag, "_sid"}, bus.served_id, m_sid);
        chk({tag, "_stv"},  bus.starve, stv_e);
    endtask

    task automatic step(input logic [3:0] p, input logic [3:0] g, input string tag);
        bus.push = p;
        bus.gnt  = g;
        model_edge(p, g);
        @(posedge clock);
        #1;
        bus.push = '0;
        bus.gnt  = '0;
        check_all(tag);
    endtask

    function automatic logic [3:0] rps4_pick();
        for (int k = 0; k < 4; k++) begin
            int c;
            c = (rr_ptr + k) % 4;
            if (m_cnt[c] > 0) return 4'(1 << c);
        end
        return 4'b0;
    endfunction

    task automatic rps4_advance(input logic [3:0] g);
        for (int c = 0; c < 4; c++) if (g[c]) rr_ptr = (c + 1) % 4;
    endtask

    // Asserts reset between edges and expects every output cleared immediately.
    task automatic do_reset();
        #3;
        reset    = 1'b1;
        bus.push = 4'hF;
        bus.gnt  = 4'h1;
        #1;
        chk("arst_req",  bus.req, 0);
        chk("arst_en",   bus.en, 0);
        chk("arst_full", bus.full, 0);
        chk("arst_sv",   bus.served_valid, 0);
        chk("arst_sid",  bus.served_id, 0);
        chk("arst_ovf",  bus.overflow, 0);
        chk("arst_gerr", bus.gnt_err, 0);
        chk("arst_stv",  bus.starve, 0);
        model_clear();
        @(posedge clock);
        #1;
        bus.push = '0;
        bus.gnt  = '0;
        reset    = 1'b0;
    endtask

    initial begin
        int served[4];
        int total;
        bus.push = '0;
        bus.gnt  = '0;
        model_clear();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        check_all("reset");

        // Single job on channel 2
        step(4'b0100, 4'b0000, "p2");
        chk("p2_req_const", bus.req, 4'b0100);
        chk("p2_en_const",  bus.en, 1);
        step(4'b0000, 4'b0100, "g2");
        chk("g2_req_const", bus.req, 4'b0000);
        chk("g2_sv_const",  bus.served_valid, 1);
        chk("g2_sid_const", bus.served_id, 2);

        // Fill channel 0, overflow, then push+grant while full
        repeat (MAXC) step(4'b0001, 4'b0000, "fill0");
        chk("fill0_full_const", bus.full[0], 1);
        step(4'b0001, 4'b0000, "ovf0");
        chk("ovf0_const", bus.overflow[0], 1);
        step(4'b0001, 4'b0001, "pg0");
        chk("pg0_full_const", bus.full[0], 1);
        repeat (MAXC) step(4'b0000, 4'b0001, "drain0");
        chk("drain0_req", bus.req[0], 0);

        // Illegal grants
        do_reset();
        step(4'b0011, 4'b0000, "p01");
        step(4'b0000, 4'b0011, "mh");
        chk("mh_gerr_const", bus.gnt_err, 1);
        chk("mh_req_const",  bus.req, 4'b0011);
        do_reset();
        step(4'b0000, 4'b1000, "empty3");
        chk("empty3_gerr_const", bus.gnt_err, 1);
        do_reset();

        // Three jobs per channel served by a rotating selector
        repeat (3) step(4'b1111, 4'b0000, "load");
        for (int i = 0; i < 4; i++) served[i] = 0;
        for (int cyc = 0; cyc < 40 && m_req() != 0; cyc++) begin
            logic [3:0] g;
            g = rps4_pick();
            step(4'b0000, g, "rot");
            rps4_advance(g);
            if (bus.served_valid) served[bus.served_id]++;
        end
        total = served[0] + served[1] + served[2] + served[3];
        chk("rot_total", total, 12);
        for (int i = 0; i < 4; i++) chk("rot_per_id", served[i], 3);
        chk("rot_req_end", bus.req, 0);
        chk("rot_en_end",  bus.en, 0);

`ifdef RPS_STARVE_MON_EN
        step(4'b0010, 4'b0000, "stv_push");
        repeat (LIMIT) step(4'b0000, 4'b0000, "stv_wait");
        chk("stv_set_const", bus.starve[1], 1);
        step(4'b0000, 4'b0010, "stv_gnt");
        chk("stv_clr_const", bus.starve[1], 0);
`endif

        // Mid-operation reset with work pending
        step(4'b1011, 4'b0000, "pre_rst");
        do_reset();
        check_all("post_rst");

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            logic [3:0] p, g;
            int mode;
            if (n % 250 == 249) do_reset();
            p    = ($urandom % 3 == 0) ? 4'($urandom) : 4'($urandom & $urandom);
            mode = $urandom % 6;
            if (mode == 0)      g = 4'b0;
            else if (mode == 5) g = 4'($urandom);
            else                g = rps4_pick();
            step(p, g, "rnd");
            if (mode != 0 && mode != 5) rps4_advance(g);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
